// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, FIFO sizing,
// the buffered entry layout and the default memory address width.
package fetch_unit_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   localparam int unsigned FIFO_DEPTH     = 2;
   localparam int unsigned CNT_W          = 2;
   localparam int unsigned DEFAULT_ADDR_W = 10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
   } fetch_entry_t;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] pc);
      return pc & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction memory port, redirect request
// and the decoupled output towards decode. master = fetch unit side.
interface fetch_unit_if import fetch_unit_pkg::*; #(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

   logic [ADDR_W-1:0] address;
   logic [31:0]       instruction;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instruction;
   logic [31:0]       out_pc;
   logic              fetch_fault;

   modport master (
      output address, out_valid, out_instruction, out_pc, fetch_fault,
      input  instruction, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  address, out_valid, out_instruction, out_pc, fetch_fault,
      output instruction, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instruction} buffer with push, pop and flush.
// entry0 always holds the head so the outputs come straight from a register.
module fetch_fifo import fetch_unit_pkg::*; (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  fetch_entry_t     push_data,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t entry0;
   fetch_entry_t entry1;

   // Storage and occupancy: reset over flush over push/pop.
   // Shift-register organisation: a pop moves entry1 into the head slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry0 <= '0;
         entry1 <= '0;
         count  <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == '0) entry0 <= push_data;
               else             entry1 <= push_data;
               count <= count + 1'b1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 1'b1;
            end
            2'b11: begin
               if (count == CNT_W'(FIFO_DEPTH)) begin
                  entry0 <= entry1;
                  entry1 <= push_data;
               end else begin
                  entry0 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = entry0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, redirect handling and a 2-entry
// output buffer towards decode.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets (FAULT state, fetch_fault=1); otherwise targets are word-aligned.
module fetch_unit import fetch_unit_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = DEFAULT_ADDR_W
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);

   state_t           state;
   state_t           next_state;
   logic [31:0]      fetch_pc;
   logic [31:0]      redirect_target;
   logic             redirect_bad;
   logic             out_fire;
   logic             fetch_fire;
   logic             fifo_full;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;

   assign out_fire   = bus.out_valid && bus.out_ready;
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign push_entry = '{pc: fetch_pc, instruction: bus.instruction};

   // Next state, redirect target and fetch decision.
   always_comb begin
      next_state = state;
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_target = bus.redirect_pc;
      redirect_bad    = |bus.redirect_pc[1:0];
`else
      redirect_target = word_align(bus.redirect_pc);
      redirect_bad    = 1'b0;
`endif
      if (bus.redirect_valid) begin
         next_state = redirect_bad ? ST_FAULT : ST_RUN;
      end
      fetch_fire = (state == ST_RUN) && !bus.redirect_valid && (!fifo_full || out_fire);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= next_state;
   end

   // Fetch PC: reset over redirect over sequential advance.
   always_ff @(posedge clk) begin
      if (reset)                   fetch_pc <= RESET_PC;
      else if (bus.redirect_valid) fetch_pc <= redirect_target;
      else if (fetch_fire)         fetch_pc <= fetch_pc + 32'd4;
   end

   fetch_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect_valid),
      .push      (fetch_fire),
      .pop       (out_fire),
      .push_data (push_entry),
      .head      (head),
      .count     (count)
   );

   assign bus.address         = fetch_pc[ADDR_W+1:2];
   assign bus.out_valid       = (count != '0);
   assign bus.out_instruction = head.instruction;
   assign bus.out_pc          = head.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.fetch_fault     = (state == ST_FAULT);
`else
   assign bus.fetch_fault     = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte PC loaded on reset.
REQ-002 Parameter ADDR_W, default 10: word-address width of the instruction memory.
REQ-003 Single clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 address  output  ADDR_W  word address to instruction_memory.
REQ-007 instruction  input  32  combinational read data from instruction_memory.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 out_valid  output  1  fetched instruction available.
REQ-011 out_ready  input  1  decode stage accepts.
REQ-012 out_instruction  output  32  head instruction.
REQ-013 out_pc  output  32  byte PC of out_instruction.
REQ-014 fetch_fault  output  1  misaligned redirect trap flag.

Function
REQ-015 SHALL hold fetch_pc (32-bit); address SHALL equal fetch_pc[ADDR_W+1:2] combinationally.
REQ-016 SHALL buffer {pc, instruction} in a 2-entry FIFO; out_valid = FIFO non-empty; out_* driven from the head, registered.
REQ-017 Fetch condition (state RUN, no redirect, and count<2, or count==2 with out_valid&&out_ready): push {fetch_pc, instruction}; fetch_pc += 4.
REQ-018 Pop on out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-019 Latency: instruction fetched in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 at the earliest.
REQ-020 Full: count==2 and no pop -> no push, fetch_pc held; out_* stable while out_valid && !out_ready.
REQ-021 Redirect (highest priority): at the edge ending cycle N, FIFO flushed, no push, fetch_pc <= redirect_pc; target appears on out_* in cycle N+2.
REQ-022 A handshake completing in the same cycle as a redirect SHALL count as consumed; all other buffered entries are discarded.
REQ-023 Wrap: fetch_pc increments modulo 2^32; address wraps from 2^ADDR_W-1 to 0 with no special handling.
REQ-024 States: RUN (fetching), FAULT (fetch stopped, FIFO empty, fetch_fault=1); RUN->FAULT on a misaligned redirect (macro builds only); FAULT->RUN on an aligned redirect.

Reset
REQ-025 On reset: fetch_pc=RESET_PC, FIFO count=0, out_valid=0, out_instruction=0, out_pc=0, fetch_fault=0, state RUN.
REQ-026 Reset mid-operation SHALL discard all buffered entries and take priority over redirect and handshake.
REQ-027 First fetch (RESET_PC) SHALL occur in the first cycle with reset low; out_valid=1 in the following cycle.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 flushes the FIFO, enters FAULT, latches fetch_fault=1.
REQ-029 Macro undefined: redirect_pc[1:0] ignored (treated as 00), FAULT unreachable, fetch_fault tied 0.

Structure
REQ-030 Shared header fetch_defs.vh SHALL hold state encodings (RUN, FAULT), FIFO depth 2, default ADDR_W.
REQ-031 Sub-module fetch_fifo (2-entry, push/pop/flush, count) SHALL be instantiated once; state machine and PC logic stay in fetch_unit.

Verification
REQ-032 Reset release, out_ready=1, memory words 0..7 distinct -> out_pc 0,4,8,...,28 on consecutive cycles from cycle 1, out_instruction = word[pc/4].
REQ-033 out_ready=0 for 5 cycles after reset -> count=2, address held at 2, out_pc stays 0; out_ready=1 -> stream resumes 0,4,8 with no gap or duplicate.
REQ-034 Redirect to 0x40 in cycle 3 -> entries flushed, out_pc=0x40 in cycle 5, then 0x44; no pre-redirect PC after cycle 3.
REQ-035 Redirect to 0xFFC (ADDR_W=10) -> address 1023 then 0, out_pc 0xFFC then 0x1000.
REQ-036 With FETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> fetch_fault=1, out_valid=0 thereafter; redirect to 0x80 -> fault clears, out_pc=0x80 two cycles later. Without the macro: redirect to 0x42 -> out_pc=0x40, fetch_fault=0.
REQ-037 reset asserted while FIFO full -> next cycle out_valid=0, fetch_pc=RESET_PC.
